// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - in-order instruction fetch with flush-aware response queue
module instruction_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pc_addr,
  input  logic             pc_flush,
  output logic             pc_stall,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_addr,
  input  logic             out_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Outstanding requests, the stale subset of them, and queued instructions
  logic [CW-1:0] pending_q, pending_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;

  // Address FIFO pointers (pending requests) and instruction queue pointers
  logic [PW-1:0] af_wr_q, af_wr_d, af_rd_q, af_rd_d;
  logic [PW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;

  logic [WIDTH-1:0] af_mem_q   [DEPTH];
  logic [WIDTH-1:0] iq_addr_q  [DEPTH];
  logic [WIDTH-1:0] iq_instr_q [DEPTH];

  logic [CW:0] used;
  logic        credit;
  logic        grant;
  logic        resp;
  logic        keep;
  logic        pop;

  // Request/response handshakes; the queue is ignored for credit on a flush since it is being cleared
  always_comb begin
    used      = {1'b0, pending_q} + (pc_flush ? '0 : {1'b0, count_q});
    credit    = used < (CW + 1)'(DEPTH);
    mem_req   = reset_n & credit;
    mem_addr  = pc_addr;
    grant     = mem_req & mem_gnt;
    pc_stall  = ~grant;
    resp      = reset_n & mem_rvalid & (pending_q != '0);
    keep      = resp & (drop_q == '0) & ~pc_flush;
    out_valid = (count_q != '0) & ~pc_flush & reset_n;
    pop       = out_valid & out_ready;
    out_instr = iq_instr_q[iq_rd_q];
    out_addr  = iq_addr_q[iq_rd_q];
  end

  // Next-state for counters and pointers; a flush marks every earlier grant stale (idempotent when held)
  always_comb begin
    pending_d = pending_q + CW'(grant) - CW'(resp);
    drop_d    = drop_q;
    if (pc_flush) begin
      drop_d = pending_q - CW'(resp);
    end else if (resp && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    count_d = pc_flush ? '0 : (count_q + CW'(keep) - CW'(pop));
    af_wr_d = af_wr_q + PW'(grant);
    af_rd_d = af_rd_q + PW'(resp);
    iq_wr_d = iq_wr_q + PW'(keep);
    iq_rd_d = pc_flush ? iq_wr_q : (iq_rd_q + PW'(pop));
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending_q <= '0;
      drop_q    <= '0;
      count_q   <= '0;
      af_wr_q   <= '0;
      af_rd_q   <= '0;
      iq_wr_q   <= '0;
      iq_rd_q   <= '0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      af_wr_q   <= af_wr_d;
      af_rd_q   <= af_rd_d;
      iq_wr_q   <= iq_wr_d;
      iq_rd_q   <= iq_rd_d;
    end
  end

  // Data storage: granted addresses, then {addr, instr} pairs for kept responses
  always_ff @(posedge clock) begin
    if (grant) begin
      af_mem_q[af_wr_q] <= pc_addr;
    end
    if (keep) begin
      iq_addr_q[iq_wr_q]  <= af_mem_q[af_rd_q];
      iq_instr_q[iq_wr_q] <= mem_rdata;
    end
  end

  // A response with nothing outstanding is a memory protocol error; it is ignored above
  assert property (@(posedge clock) disable iff (!reset_n) mem_rvalid |-> (pending_q != '0));

endmodule
